// File: rtl/bus_arbiter_rr4_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter:
// FSM state encodings, default timeout sizing and a ring-index helper.
package bus_arbiter_rr4_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT  = 15;
    localparam int DEFAULT_TO_WIDTH = 4;

    // Position 'offset' steps after 'base' on the four-entry ring; the
    // two-bit add wraps 3 -> 0 for free.
    function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr4_if.sv
// Bundle of requester, target and shared-bus signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view
// (bus masters driving req/data plus the target driving ack).
interface bus_arbiter_rr4_if;

    logic [3:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic        ack;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [31:0] bus_data;
    logic        bus_valid;
    logic        err;

    modport slave (
        input  req, d0, d1, d2, d3, ack,
        output gnt, sel, bus_data, bus_valid, err
    );

    modport master (
        output req, d0, d1, d2, d3, ack,
        input  gnt, sel, bus_data, bus_valid, err
    );

endinterface

// File: rtl/bus_arbiter_rr4_rr_pick4.sv
// Combinational round-robin picker: returns the first asserted request
// found when scanning ptr, ptr+1, ... (mod 4).
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       valid
);
    import bus_arbiter_rr4_pkg::*;

    // Scan from the farthest ring position back to ptr so the closest
    // asserted request is the last (and therefore winning) assignment.
    always_comb begin
        win = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[rr_index(ptr, 2'(i))]) begin
                win = rr_index(ptr, 2'(i));
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Four-requester round-robin arbiter sharing one 32-bit bus. A grant is held
// until the target acks, the requester withdraws, or the timeout expires;
// each transfer is followed by at least one idle turnaround cycle.
module bus_arbiter_rr4 #(
    parameter int TIMEOUT  = bus_arbiter_rr4_pkg::DEFAULT_TIMEOUT,
    parameter int TO_WIDTH = bus_arbiter_rr4_pkg::DEFAULT_TO_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    bus_arbiter_rr4_if.slave   bus
);
    import bus_arbiter_rr4_pkg::*;

    localparam logic [TO_WIDTH-1:0] TIMEOUT_CNT = TO_WIDTH'(TIMEOUT);

    arb_state_t          state;
    logic [1:0]          ptr;
    logic [TO_WIDTH-1:0] cnt;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                bus_valid;
    logic                err;
    logic [1:0]          win;
    logic                win_valid;
    logic [31:0]         mux_out;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (win),
        .valid (win_valid)
    );

    // Arbitration FSM with registered grant, select, valid and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= 2'd0;
            cnt       <= '0;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            bus_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    err <= 1'b0;
                    if (win_valid) begin
                        state     <= ARB_GRANT;
                        gnt       <= 4'b0001 << win;
                        sel       <= win;
                        bus_valid <= 1'b1;
                        cnt       <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (bus.ack) begin
                        state     <= ARB_IDLE;
                        gnt       <= 4'b0000;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                        err       <= 1'b0;
                    end else if (!bus.req[sel]) begin
                        state     <= ARB_IDLE;
                        gnt       <= 4'b0000;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                        err       <= 1'b0;
                    end else if (cnt == TIMEOUT_CNT) begin
                        state     <= ARB_IDLE;
                        gnt       <= 4'b0000;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                        err       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    gnt       <= 4'b0000;
                    bus_valid <= 1'b0;
                    err       <= 1'b0;
                end
            endcase
        end
    end

    // 4:1 data mux steered by the registered select; data is not registered.
    always_comb begin
        case (sel)
            2'd0:    mux_out = bus.d0;
            2'd1:    mux_out = bus.d1;
            2'd2:    mux_out = bus.d2;
            default: mux_out = bus.d3;
        endcase
    end

    assign bus.bus_data  = mux_out & {32{bus_valid}};
    assign bus.gnt       = gnt;
    assign bus.sel       = sel;
    assign bus.bus_valid = bus_valid;
    assign bus.err       = err;

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Self-checking bench for bus_arbiter_rr4 (TIMEOUT=4): a cycle table of
// {req, ack} -> {gnt, sel, valid, err} records fed through a scoreboard
// queue, plus hand sequences for async reset and combinational data.
module tb_bus_arbiter_rr4;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic [1:0]  sel;
        logic        valid;
        logic        err;
        logic [31:0] data;
        int          tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in [4];
    vec_t        vecs [$];
    exp_t        sb_q [$];
    int          check_count = 0;
    int          pass_count  = 0;
    int          step        = 0;

    bus_arbiter_rr4_if bus_if ();

    assign bus_if.d0 = data_in[0];
    assign bus_if.d1 = data_in[1];
    assign bus_if.d2 = data_in[2];
    assign bus_if.d3 = data_in[3];

    bus_arbiter_rr4 #(
        .TIMEOUT  (4),
        .TO_WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] expData(input logic [1:0] s, input logic v);
        return v ? data_in[s] : 32'h0;
    endfunction

    function automatic void addVec(input logic [3:0] req, input logic ack, input logic [3:0] gnt,
                                   input logic [1:0] sel, input logic valid, input logic err);
        vec_t v;
        v.req = req; v.ack = ack; v.gnt = gnt; v.sel = sel; v.valid = valid; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic checkValue(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp)
            $display("[TB] FAIL %s (step %0d): got %h expected %h", name, tag, act, exp);
        else
            pass_count++;
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        bus_if.req = v.req;
        bus_if.ack = v.ack;
        e.gnt = v.gnt; e.sel = v.sel; e.valid = v.valid; e.err = v.err;
        e.data = expData(v.sel, v.valid);
        e.tag = step;
        sb_q.push_back(e);
        step++;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            checkValue("gnt",       e.tag, 32'(bus_if.gnt),       32'(e.gnt));
            checkValue("sel",       e.tag, 32'(bus_if.sel),       32'(e.sel));
            checkValue("bus_valid", e.tag, 32'(bus_if.bus_valid), 32'(e.valid));
            checkValue("err",       e.tag, 32'(bus_if.err),       32'(e.err));
            checkValue("bus_data",  e.tag, bus_if.bus_data,       e.data);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic checkIdleOutputs(input int tag);
        checkValue("rst_gnt",   tag, 32'(bus_if.gnt),       32'h0);
        checkValue("rst_sel",   tag, 32'(bus_if.sel),       32'h0);
        checkValue("rst_valid", tag, 32'(bus_if.bus_valid), 32'h0);
        checkValue("rst_err",   tag, 32'(bus_if.err),       32'h0);
        checkValue("rst_data",  tag, bus_if.bus_data,       32'h0);
    endtask

    initial begin
        vec_t h;
        data_in[0] = 32'h1000_0000;
        data_in[1] = 32'h1111_1111;
        data_in[2] = 32'hDEAD_BEEF;
        data_in[3] = 32'h3333_3333;
        bus_if.req = 4'b0000;
        bus_if.ack = 1'b0;
        rst_n = 1'b1;

        // Fairness from ptr=0 with every requester active: order 0,1,2,3,0.
        addVec(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        addVec(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        addVec(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        addVec(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Single request to 2, ack on third grant edge (ptr ends at 3).
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0);
        // Timeout: five granted cycles, one-cycle err, then regrant to 0.
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        // Withdraw from 1 (ptr=2), then 0011 wraps to 0, then 1.
        addVec(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0);
        addVec(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0);
        addVec(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        // Other requesters toggling during a grant do not disturb it.
        addVec(4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0);
        addVec(4'b1010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0);
        addVec(4'b1010, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        addVec(4'b1010, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);
        // Collision: ack, withdraw and cnt==TIMEOUT on one edge -> clean completion.
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0);
        addVec(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0);
        addVec(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0);
        addVec(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0);
        addVec(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Power-on reset, no clock edge involved.
        #2 rst_n = 1'b0;
        #1 checkIdleOutputs(-1);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) runVec(vecs[i]);

        // Bus data tracks the granted source without a clock edge.
        h = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        runVec(h);
        data_in[2] = 32'h0BAD_F00D;
        #1 checkValue("data_follow", step, bus_if.bus_data, 32'h0BAD_F00D);
        h = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
        runVec(h);
        h = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        runVec(h);

        // Asynchronous reset in the middle of a grant.
        rst_n = 1'b0;
        #1 checkIdleOutputs(-2);
        bus_if.req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer restarts at 0 after reset: 1001 goes to requester 0.
        h = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        runVec(h);
        h = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        runVec(h);

        if (sb_q.size() != 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
